// File: rtl/edge_pulse_bank_if.sv
// rtl/edge_pulse_bank_if.sv - trigger/config/strobe bundle for edge_pulse_bank
//
// Purpose: groups the per-channel trigger inputs, shared configuration and
// per-channel outputs of edge_pulse_bank so they travel as one port.
//
// Signals (ch i = bit i unless noted):
//   trigger          master->slave  CHANNELS        async trigger inputs
//   edge_mode        master->slave  2*CHANNELS      ch i = [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   debounce_cycles  master->slave  DEBOUNCE_W      extra stable cycles before level changes
//   pulse_len        master->slave  PULSE_LEN_W     advance width minus 1
//   flag_clear       master->slave  CHANNELS        clear sticky event_flag bit i
//   advance          slave->master  CHANNELS        advance strobe per channel
//   level            slave->master  CHANNELS        debounced, synchronised trigger level
//   event_flag       slave->master  CHANNELS        sticky qualified-edge flag per channel
interface edge_pulse_bank_if #(
  parameter int CHANNELS    = 8,
  parameter int DEBOUNCE_W  = 4,
  parameter int PULSE_LEN_W = 3
);
  logic [CHANNELS-1:0]    trigger;
  logic [2*CHANNELS-1:0]  edge_mode;
  logic [DEBOUNCE_W-1:0]  debounce_cycles;
  logic [PULSE_LEN_W-1:0] pulse_len;
  logic [CHANNELS-1:0]    flag_clear;
  logic [CHANNELS-1:0]    advance;
  logic [CHANNELS-1:0]    level;
  logic [CHANNELS-1:0]    event_flag;

  modport master (
    output trigger, edge_mode, debounce_cycles, pulse_len, flag_clear,
    input  advance, level, event_flag
  );

  modport slave (
    input  trigger, edge_mode, debounce_cycles, pulse_len, flag_clear,
    output advance, level, event_flag
  );
endinterface

// File: rtl/edge_pulse_bank.sv
// rtl/edge_pulse_bank.sv - multi-channel synchronise/debounce/edge-to-pulse bank
//
// Purpose: each channel synchronises an asynchronous trigger, debounces it with
// a shared programmable stable time, and emits a programmable-width advance
// strobe on the selected edge(s). A sticky event flag records qualified edges.
//
// Ports:
//   clock    in   system clock, all flops on posedge
//   reset_n  in   synchronous, active-low reset
//   bus      slave modport of edge_pulse_bank_if (trigger/config in, strobes out)
module edge_pulse_bank #(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 4,
  parameter int PULSE_LEN_W = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  edge_pulse_bank_if.slave bus
);

  localparam logic [DEBOUNCE_W-1:0]  DEB_ONE  = 1;
  localparam logic [PULSE_LEN_W:0]   PCNT_ONE = 1;

  // Per-channel state. The synchroniser is reset like everything else so a
  // trigger held high through reset is seen as a fresh rising edge.
  logic [CHANNELS-1:0][SYNC_STAGES-1:0] r_sync;
  logic [CHANNELS-1:0]                  r_level;
  logic [CHANNELS-1:0][DEBOUNCE_W-1:0]  r_cnt;
  logic [CHANNELS-1:0][PULSE_LEN_W:0]   r_pcnt;
  logic [CHANNELS-1:0]                  r_flag;

  logic [CHANNELS-1:0] w_s;
  logic [CHANNELS-1:0] w_diff;
  logic [CHANNELS-1:0] w_flip;
  logic [CHANNELS-1:0] w_qual;
  logic [CHANNELS-1:0] w_advance;
  logic [PULSE_LEN_W:0] w_reload;

  // pulse_len encodes width-1; the extra counter bit holds pulse_len+1 for
  // the maximum setting without wrapping.
  assign w_reload = {1'b0, bus.pulse_len} + PCNT_ONE;

  always_comb begin
    w_s    = '0;
    w_diff = '0;
    w_flip = '0;
    w_qual = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_s[c]    = r_sync[c][SYNC_STAGES-1];
      w_diff[c] = (w_s[c] != r_level[c]);
      // The flip happens on the (debounce_cycles+1)-th consecutive edge of
      // disagreement; a counter that already exceeds a freshly lowered
      // threshold flips immediately.
      w_flip[c] = w_diff[c] && (r_cnt[c] >= bus.debounce_cycles);
      // Direction comes from the old level: low->high uses mode bit0,
      // high->low uses mode bit1.
      w_qual[c] = w_flip[c] &&
                  (r_level[c] ? bus.edge_mode[2*c+1] : bus.edge_mode[2*c]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_level <= '0;
      r_cnt   <= '0;
      r_pcnt  <= '0;
      r_flag  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], bus.trigger[c]};

        if (!w_diff[c]) begin
          r_cnt[c] <= '0;
        end else if (w_flip[c]) begin
          r_level[c] <= w_s[c];
          r_cnt[c]   <= '0;
        end else begin
          r_cnt[c] <= r_cnt[c] + DEB_ONE;
        end

        // A retrigger reloads the running count, so the strobe is extended
        // without a gap rather than producing a second strobe.
        if (w_qual[c]) begin
          r_pcnt[c] <= w_reload;
        end else if (r_pcnt[c] != '0) begin
          r_pcnt[c] <= r_pcnt[c] - PCNT_ONE;
        end

        // Set has priority over a simultaneous clear.
        if (w_qual[c]) begin
          r_flag[c] <= 1'b1;
        end else if (bus.flag_clear[c]) begin
          r_flag[c] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_advance = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_advance[c] = (r_pcnt[c] != '0);
    end
  end

  assign bus.advance    = w_advance;
  assign bus.level      = r_level;
  assign bus.event_flag = r_flag;

endmodule
